// File: rtl/mult_ctrl_pkg.sv
// Shared encodings for the execute-stage multiply controller.
// Opcode values match the EX decode of ex_op.
package mult_ctrl_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MFHI  = 3'd3;
    localparam logic [2:0] OP_MFLO  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int unsigned DEF_MAX_LAT = 40;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

endpackage

// File: rtl/mult_ctrl.sv
// HI/LO owner and sequencer for the serial multiplier: launches one multiply at a time,
// stalls EX while it is pending, commits or discards the product, and times out a dead unit.
module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MAX_LAT = DEF_MAX_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [2:0]         ex_op,
    input  logic [WIDTH-1:0]   ex_rs,
    input  logic [WIDTH-1:0]   ex_rt,
    input  logic               flush,
    output logic               stall,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid,
    output logic               m_start,
    output logic               m_sgn,
    output logic [WIDTH-1:0]   m_srcA,
    output logic [WIDTH-1:0]   m_srcB,
    input  logic [2*WIDTH-1:0] m_prod,
    input  logic               m_prodv,
    output logic               busy,
    output logic               err
);

    localparam int unsigned     CntW    = $clog2(MAX_LAT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_LAT - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] srca_q, srca_d;
    logic [WIDTH-1:0] srcb_q, srcb_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cancel_q, cancel_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic             sgn_q, sgn_d;

    logic op_live;
    logic op_real;
    logic idle;

    assign op_live = ex_valid & ~flush;
    // Opcode 7 is reserved and behaves as a NOP, so it never stalls.
    assign op_real = (ex_op != OP_NOP) && (ex_op != 3'd7);
    assign idle    = (state_q == S_IDLE);

    assign stall    = op_live & op_real & ~idle;
    assign rd_valid = op_live & idle & ((ex_op == OP_MFHI) | (ex_op == OP_MFLO));
    assign busy     = ~idle;
    assign err      = err_q;
    assign m_start  = start_q;
    assign m_sgn    = sgn_q;
    assign m_srcA   = srca_q;
    assign m_srcB   = srcb_q;

    always_comb begin
        rd_data = '0;
        if (rd_valid) begin
            rd_data = (ex_op == OP_MFHI) ? hi_q : lo_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        cnt_d    = cnt_q;
        cancel_d = cancel_q;
        err_d    = err_q;
        start_d  = 1'b0;
        sgn_d    = sgn_q;

        unique case (state_q)
            S_IDLE: begin
                if (op_live) begin
                    case (ex_op)
                        OP_MULT, OP_MULTU: begin
                            srca_d   = ex_rs;
                            srcb_d   = ex_rt;
                            sgn_d    = (ex_op == OP_MULT);
                            cancel_d = 1'b0;
                            start_d  = 1'b1;
                            state_d  = S_ISSUE;
                        end
                        OP_MTHI: hi_d = ex_rs;
                        OP_MTLO: lo_d = ex_rs;
                        default: ;
                    endcase
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
                if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (flush) begin
                    cancel_d = 1'b1;
                end
                // A flush coinciding with the product also discards it.
                if (m_prodv) begin
                    if (!cancel_q && !flush) begin
                        hi_d = m_prod[2*WIDTH-1:WIDTH];
                        lo_d = m_prod[WIDTH-1:0];
                    end
                    state_d = S_IDLE;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            srca_q   <= '0;
            srcb_q   <= '0;
            cnt_q    <= '0;
            cancel_q <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            sgn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            cnt_q    <= cnt_d;
            cancel_q <= cancel_d;
            err_q    <= err_d;
            start_q  <= start_d;
            sgn_q    <= sgn_d;
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl with a behavioural serial multiplier of programmable latency.
// Expected MF results and multiplier launches are queued by the driver and popped by a monitor.
module tb_mult_ctrl;

    localparam int unsigned MaxLat = 40;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] MULT  = 3'd1;
    localparam logic [2:0] MULTU = 3'd2;
    localparam logic [2:0] MFHI  = 3'd3;
    localparam logic [2:0] MFLO  = 3'd4;
    localparam logic [2:0] MTHI  = 3'd5;
    localparam logic [2:0] MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_op = 3'd0;
    logic [31:0] ex_rs = '0;
    logic [31:0] ex_rt = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        m_start;
    logic        m_sgn;
    logic [31:0] m_srcA;
    logic [31:0] m_srcB;
    logic [63:0] m_prod = '0;
    logic        m_prodv = 1'b0;
    logic        busy;
    logic        err;

    mult_ctrl #(
        .WIDTH   (32),
        .MAX_LAT (MaxLat)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .ex_op    (ex_op),
        .ex_rs    (ex_rs),
        .ex_rt    (ex_rt),
        .flush    (flush),
        .stall    (stall),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .m_start  (m_start),
        .m_sgn    (m_sgn),
        .m_srcA   (m_srcA),
        .m_srcB   (m_srcB),
        .m_prod   (m_prod),
        .m_prodv  (m_prodv),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] ref_prod(logic sgn, logic [31:0] a, logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Behavioural serial multiplier: product appears lat+1 cycles after the m_start cycle.
    int          lat     = 4;
    bit          no_resp = 1'b0;
    int          cd      = 0;
    bit          mpend   = 1'b0;
    logic [63:0] mres    = '0;

    always @(posedge clk) begin
        m_prodv <= 1'b0;
        if (m_start) begin
            mpend <= 1'b1;
            cd    <= lat;
            mres  <= ref_prod(m_sgn, m_srcA, m_srcB);
        end else if (mpend) begin
            if (cd == 1) begin
                mpend <= 1'b0;
                if (!no_resp) begin
                    m_prodv <= 1'b1;
                    m_prod  <= mres;
                end
            end
            cd <= cd - 1;
        end
    end

    // Architectural reference state.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_err = 1'b0;
    logic [63:0] pend_prod = '0;
    bit          pend_cancel = 1'b0;

    logic [31:0] rdq[$];
    logic [64:0] iq[$];

    always @(negedge clk) begin
        logic [31:0] er;
        logic [64:0] ei;
        if (rd_valid) begin
            if (rdq.size() == 0) begin
                chk("rd_valid_unexpected", rd_valid, 0);
            end else begin
                er = rdq.pop_front();
                chk("rd_data", rd_data, er);
            end
        end
        if (m_start) begin
            if (iq.size() == 0) begin
                chk("m_start_unexpected", m_start, 0);
            end else begin
                ei = iq.pop_front();
                chk("m_sgn", m_sgn, ei[64]);
                chk("m_srcA", m_srcA, ei[63:32]);
                chk("m_srcB", m_srcB, ei[31:0]);
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic fl);
        ex_valid = v;
        ex_op    = op;
        ex_rs    = rs;
        ex_rt    = rt;
        flush    = fl;
    endtask

    // One EX cycle; bsy is the bench's own view of whether a multiply is outstanding.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic fl, input bit bsy);
        bit live;
        live = v && !fl;
        drive(v, op, rs, rt, fl);
        if (bsy && fl) pend_cancel = 1'b1;
        if (!bsy && live) begin
            case (op)
                MFHI: rdq.push_back(m_hi);
                MFLO: rdq.push_back(m_lo);
                MTHI: m_hi = rs;
                MTLO: m_lo = rs;
                MULT, MULTU: begin
                    iq.push_back({op == MULT, rs, rt});
                    pend_prod   = ref_prod(op == MULT, rs, rt);
                    pend_cancel = 1'b0;
                end
                default: ;
            endcase
        end
        @(negedge clk);
        chk("stall", stall, bsy && live && op >= 3'd1 && op <= 3'd6);
        chk("busy", busy, bsy);
        chk("err", err, m_err);
        @(posedge clk);
        #1;
    endtask

    // Read with a spec-given expected value, in an idle cycle.
    task automatic rd_check(input logic [2:0] op, input logic [31:0] exp);
        drive(1'b1, op, 32'h0, 32'h0, 1'b0);
        rdq.push_back(exp);
        @(negedge clk);
        chk("stall_idle", stall, 0);
        chk("busy_idle", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic mult_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int l, input bit rnd, input logic [2:0] hold, input int fl_at);
        int n;
        lat = l;
        step(1'b1, op, a, b, 1'b0, 1'b0);
        n = no_resp ? MaxLat + 1 : l + 2;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                     $urandom_range(0, 7) == 0, 1'b1);
            end else begin
                step(1'b1, hold, $urandom, $urandom, i == fl_at, 1'b1);
            end
        end
        if (no_resp) m_err = 1'b1;
        else if (!pend_cancel) {m_hi, m_lo} = pend_prod;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        v, fl;
        logic [2:0]  op;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_srcA", m_srcA, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, MULT, 32'd7, 32'd9, 1'b0, 1'b0);
        rd_check(MFHI, 32'h0);
        rd_check(MFLO, 32'h0);

        // MULTU 3x5, latency 8, MFHI held in EX while busy.
        mult_txn(MULTU, 32'd3, 32'd5, 8, 1'b0, MFHI, -1);
        rd_check(MFHI, 32'h0000_0000);
        rd_check(MFLO, 32'h0000_000F);

        // Signed multiply with MFLO held; it completes on the first idle cycle.
        mult_txn(MULT, 32'h00FF_FFFF, 32'h80FF_FFFF, 6, 1'b0, MFLO, -1);
        rd_check(MFLO, 32'h7E00_0001);
        rd_check(MFHI, 32'hFF81_0000);

        // Flush in WAIT cycle 3 cancels the commit.
        step(1'b1, MTHI, 32'hAAAA_0000, 32'h0, 1'b0, 1'b0);
        step(1'b1, MTLO, 32'h0000_5555, 32'h0, 1'b0, 1'b0);
        mult_txn(MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 7, 1'b0, NOP, 3);
        rd_check(MFHI, 32'hAAAA_0000);
        rd_check(MFLO, 32'h0000_5555);

        // Dead multiplier: watchdog fires, then a normal multiply still works.
        no_resp = 1'b1;
        mult_txn(MULT, 32'd11, 32'd13, 5, 1'b0, MFHI, -1);
        no_resp = 1'b0;
        rd_check(MFHI, 32'hAAAA_0000);
        mult_txn(MULT, 32'hFFFF_FFFE, 32'd3, 4, 1'b0, NOP, -1);
        rd_check(MFLO, 32'hFFFF_FFFA);
        rd_check(MFHI, 32'hFFFF_FFFF);
        step(1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset mid-WAIT; the late product must be ignored.
        lat = 10;
        step(1'b1, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b1);
        rst   = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
        m_err = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_m_srcB", m_srcB, 0);
        chk("rst_mid_m_sgn", m_sgn, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        rd_check(MFHI, 32'h0);
        rd_check(MFLO, 32'h0);

        // MTHI is visible to an MFHI on the very next cycle.
        step(1'b1, MTHI, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        rd_check(MFHI, 32'h1234_5678);

        // Back-to-back multiplies, second issued on the first idle cycle.
        mult_txn(MULTU, 32'd100, 32'd200, 3, 1'b1, NOP, -1);
        mult_txn(MULT, 32'hFFFF_FFFF, 32'd5, 2, 1'b1, NOP, -1);
        step(1'b1, MFLO, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            v  = ($urandom_range(0, 7) != 0);
            fl = ($urandom_range(0, 7) == 0);
            op = 3'($urandom_range(0, 7));
            if (v && !fl && (op == MULT || op == MULTU)) begin
                mult_txn(op, $urandom, $urandom, $urandom_range(1, 20), 1'b1, NOP, -1);
            end else begin
                step(v, op, $urandom, $urandom, fl, 1'b0);
            end
        end
        step(1'b1, MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, MFLO, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b0);

        chk("rdq_drained", rdq.size(), 0);
        chk("iq_drained", iq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
